// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the program feeder.
//   - opcode constants for the instruction word
//   - bit positions of the opcode, X and Y fields
//   - feeder FSM state type
//   - opcode() helper that extracts the opcode field from a word
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Instruction field positions: opcode [15:13], X [12:10], Y [9:7].
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int X_HI   = 12;
  localparam int X_LO   = 10;
  localparam int Y_HI   = 9;
  localparam int Y_LO   = 7;

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, IMM, WAIT} feeder_state_t;

  function automatic logic [2:0] opcode(input logic [15:0] w);
    return w[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/prog_ram.sv
// prog_ram: DEPTH x 16 program store.
//   clk, rst       : clock; rst (sync, high) clears only the read register
//   we/waddr/wdata : synchronous write port
//   re/raddr       : read enable and address; data appears next cycle
//   rdata          : registered read data, held whenever re is low
module prog_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // Storage has no reset; contents survive a Reset of the feeder.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/proc_feeder.sv
// proc_feeder: program sequencer feeding the processor core.
// Walks program RAM from address 0 to the latched last address, presenting
// each instruction on DIN with Run high, supplying the immediate word the
// cycle after an mvi, and waiting for the core's Done before advancing.
//   Clock, Reset        : clock, synchronous active-high reset
//   Load_en/addr/data   : program RAM write (IDLE only)
//   Start, Last_addr    : begin a run over 0..Last_addr (IDLE only)
//   Done                : core instruction-complete strobe
//   DIN, Run, Busy, Pc  : word to core, instruction in flight, not IDLE, address
//   Finished            : one-cycle pulse after the last instruction completes
// Optional: define PROC_FEEDER_WDOG_EN to add parameter WDOG_CYC and a sticky
// Error output raised when Done does not arrive within WDOG_CYC cycles.
module proc_feeder
  import proc_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
`ifdef PROC_FEEDER_WDOG_EN
  ,
  parameter int WDOG_CYC = 15
`endif
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Load_en,
  input  logic [AW-1:0] Load_addr,
  input  logic [15:0]   Load_data,
  input  logic          Start,
  input  logic [AW-1:0] Last_addr,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic          Busy,
  output logic          Finished,
`ifdef PROC_FEEDER_WDOG_EN
  output logic          Error,
`endif
  output logic [AW-1:0] Pc
);

  feeder_state_t state;
  logic [AW-1:0] last_q;
  logic          step2_q;   // current instruction occupies two words (mvi)
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW:0]   nxt;       // one extra bit so Pc+step past DEPTH-1 still compares

`ifdef PROC_FEEDER_WDOG_EN
  localparam int CW = $clog2(WDOG_CYC + 1);
  logic [CW-1:0] wd_cnt;
  logic          err_q;
  assign Error = err_q;
`endif

  assign wr_en = Load_en && (state == IDLE);

  always_comb begin
    rd_en   = (state == FETCH) || (state == ISSUE);
    // ISSUE prefetches the word after the instruction (immediate for mvi).
    rd_addr = (state == ISSUE) ? (Pc + AW'(1)) : Pc;
    nxt     = {1'b0, Pc} + (step2_q ? (AW+1)'(2) : (AW+1)'(1));
  end

  prog_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (Clock),
    .rst   (Reset),
    .we    (wr_en),
    .waddr (Load_addr),
    .wdata (Load_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (DIN)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      Pc       <= '0;
      last_q   <= '0;
      step2_q  <= 1'b0;
      Run      <= 1'b0;
      Busy     <= 1'b0;
      Finished <= 1'b0;
`ifdef PROC_FEEDER_WDOG_EN
      wd_cnt   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      Finished <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          last_q <= Last_addr;
          Pc     <= '0;
          Busy   <= 1'b1;
          state  <= FETCH;
`ifdef PROC_FEEDER_WDOG_EN
          err_q  <= 1'b0;
`endif
        end
        FETCH: begin
          Run   <= 1'b1;
          state <= ISSUE;
`ifdef PROC_FEEDER_WDOG_EN
          wd_cnt <= '0;
`endif
        end
        ISSUE: begin
          // DIN holds the instruction word here; Done is not looked at.
          step2_q <= (opcode(DIN) == OP_MVI);
          state   <= (opcode(DIN) == OP_MVI) ? IMM : WAIT;
        end
        IMM, WAIT: begin
          if (Done) begin
            Run <= 1'b0;
            if (nxt > {1'b0, last_q}) begin
              Pc       <= '0;
              Busy     <= 1'b0;
              Finished <= 1'b1;
              state    <= IDLE;
            end else begin
              Pc    <= nxt[AW-1:0];
              state <= FETCH;
            end
          end else begin
            state <= WAIT;
`ifdef PROC_FEEDER_WDOG_EN
            if (wd_cnt == CW'(WDOG_CYC - 1)) begin
              err_q <= 1'b1;
              Pc    <= '0;
              Run   <= 1'b0;
              Busy  <= 1'b0;
              state <= IDLE;
            end else begin
              wd_cnt <= wd_cnt + CW'(1);
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_feeder.sv
module tb_proc_feeder;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          Clock = 1'b0;
  logic          Reset, Load_en, Start, Done;
  logic [AW-1:0] Load_addr, Last_addr;
  logic [15:0]   Load_data;
  logic [15:0]   DIN;
  logic          Run, Busy, Finished;
  logic [AW-1:0] Pc;
`ifdef PROC_FEEDER_WDOG_EN
  logic          Error;
`endif

  proc_feeder #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .Load_en(Load_en), .Load_addr(Load_addr),
    .Load_data(Load_data), .Start(Start), .Last_addr(Last_addr), .Done(Done),
    .DIN(DIN), .Run(Run), .Busy(Busy), .Finished(Finished),
`ifdef PROC_FEEDER_WDOG_EN
    .Error(Error),
`endif
    .Pc(Pc)
  );

  always #5 Clock = ~Clock;

  // One expected cycle: outputs during the cycle plus the Done value to drive.
  typedef struct {
    logic [15:0]   din;
    logic          run, busy, fin;
    logic [AW-1:0] pc;
    logic          done;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mm [DEPTH];   // model of program contents
  logic [15:0] last_din;     // model of the word the feeder last read
  logic [15:0] obs[$];       // distinct DIN values seen while Run
  int          run_cnt, fin_cnt;
  int          n_cmp = 0, n_bad = 0;

  function automatic exp_t mk(logic [15:0] din, logic run, logic busy, logic fin,
                              int pc, logic done);
    exp_t e;
    e.din = din; e.run = run; e.busy = busy; e.fin = fin;
    e.pc = AW'(pc); e.done = done;
    return e;
  endfunction

  function automatic exp_t idle_e();
    return mk(last_din, 1'b0, 1'b0, 1'b0, 0, 1'b1);  // Done in IDLE is harmless
  endfunction

  // Expected trace of a whole run. d = cycle after ISSUE on which Done arrives.
  // Done is also driven in FETCH and ISSUE, where it must have no effect.
  function automatic void gen(int last, int d);
    int pc = 0;
    int nxt;
    logic [15:0] nd;
    q.delete();
    for (int guard = 0; guard < DEPTH + 1; guard++) begin
      q.push_back(mk(last_din, 1'b0, 1'b1, 1'b0, pc, 1'b1));      // fetch
      q.push_back(mk(mm[pc], 1'b1, 1'b1, 1'b0, pc, 1'b1));        // issue
      nd = mm[(pc + 1) % DEPTH];
      for (int j = 1; j <= d; j++)
        q.push_back(mk(nd, 1'b1, 1'b1, 1'b0, pc, j == d));
      last_din = nd;
      nxt = pc + ((mm[pc][15:13] == 3'b001) ? 2 : 1);
      if (nxt > last) break;
      pc = nxt;
    end
    q.push_back(mk(last_din, 1'b0, 1'b0, 1'b1, 0, 1'b0));         // finished
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Compare outputs of the current cycle, drive Done, advance one clock.
  task automatic step(input exp_t e);
    if (Run) run_cnt++;
    if (Finished) fin_cnt++;
    if (Run && (obs.size() == 0 || obs[$] != DIN)) obs.push_back(DIN);
    chk("din", DIN, e.din);
    chk("run", Run, e.run);
    chk("busy", Busy, e.busy);
    chk("finished", Finished, e.fin);
    chk("pc", Pc, e.pc);
    Done = e.done;
    @(posedge Clock); #1;
    Done = 0; Start = 0; Load_en = 0; Reset = 0;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    Load_en = 1; Load_addr = AW'(a); Load_data = d;
    step(idle_e());
    mm[a] = d;
  endtask

  // kind 1: Start+Load while busy at trace index inj; kind 2: Reset there.
  task automatic start_run(input int last, input int d, input int inj, input int kind,
                           input bit ld, input logic [15:0] ldd);
    run_cnt = 0; fin_cnt = 0; obs.delete();
    Start = 1; Last_addr = AW'(last);
    if (ld) begin Load_en = 1; Load_addr = '0; Load_data = ldd; end
    step(idle_e());
    if (ld) mm[0] = ldd;
    Last_addr = ~AW'(last);   // must already be latched
    gen(last, d);
    foreach (q[i]) begin
      if (i == inj && kind == 1) begin
        Start = 1; Last_addr = '0; Load_en = 1; Load_addr = '0; Load_data = 16'hdead;
      end
      if (i == inj && kind == 2) begin
        Reset = 1;
        step(q[i]);
        last_din = 16'h0000;
        step(idle_e());
        return;
      end
      step(q[i]);
    end
    step(idle_e());
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    Reset = 1; Load_en = 0; Start = 0; Done = 0;
    Load_addr = '0; Last_addr = '0; Load_data = '0;
    last_din = 16'h0000;
    repeat (2) @(posedge Clock);
    #1; Reset = 0;

    // Reset state
    step(idle_e());

    for (int i = 0; i < DEPTH; i++) load(i, 16'h8000 | 16'(i));

    // mvi R0,#5 ; mv R1,R0
    load(0, 16'h2000); load(1, 16'h0005); load(2, 16'h0400);
    start_run(2, 1, -1, 0, 1'b0, 16'h0);
    chk("t1_din0", obs[0], 16'h2000);
    chk("t1_din1", obs[1], 16'h0005);
    chk("t1_din2", obs[2], 16'h0400);
    chk("t1_fin_cnt", fin_cnt, 1);
    chk("t1_pc", Pc, 0);

    // Single add, Done withheld 5 cycles
    load(0, 16'h4000);
    start_run(0, 6, -1, 0, 1'b0, 16'h0);
    chk("t2_run_cycles", run_cnt, 7);
    chk("t2_fin_cnt", fin_cnt, 1);

    // mvi at the last address of the RAM: immediate wraps to address 0
    load(0, 16'h1234); load(31, 16'h2000);
    start_run(31, 1, -1, 0, 1'b0, 16'h0);
    chk("t3_imm_wrap", obs[$], 16'h1234);
    chk("t3_fin_cnt", fin_cnt, 1);

    // Reset during WAIT, then rerun with RAM intact
    start_run(2, 4, 3, 2, 1'b0, 16'h0);
    chk("t4_busy_after_rst", Busy, 0);
    start_run(2, 1, -1, 0, 1'b0, 16'h0);
    chk("t4_rerun_din0", obs[0], 16'h1234);

    // Start and Load while busy are ignored
    start_run(2, 3, 3, 1, 1'b0, 16'h0);
    start_run(2, 1, -1, 0, 1'b0, 16'h0);
    chk("t5_ram_kept", obs[0], 16'h1234);

    // Load and Start in the same IDLE cycle
    start_run(0, 1, -1, 0, 1'b1, 16'h0c00);
    chk("t5_load_start", obs[0], 16'h0c00);

`ifdef PROC_FEEDER_WDOG_EN
    // Done never arrives: watchdog returns to IDLE with Error and no Finished
    load(0, 16'h4000);
    run_cnt = 0; fin_cnt = 0; obs.delete();
    Start = 1; Last_addr = '0;
    step(mk(last_din, 1'b0, 1'b0, 1'b0, 0, 1'b0));
    step(mk(last_din, 1'b0, 1'b1, 1'b0, 0, 1'b0));
    step(mk(mm[0], 1'b1, 1'b1, 1'b0, 0, 1'b0));
    last_din = mm[1];
    for (int j = 0; j < 15; j++) step(mk(last_din, 1'b1, 1'b1, 1'b0, 0, 1'b0));
    chk("wd_error", Error, 1);
    step(mk(last_din, 1'b0, 1'b0, 1'b0, 0, 1'b0));
    chk("wd_fin_cnt", fin_cnt, 0);
    start_run(0, 1, -1, 0, 1'b0, 16'h0);
    chk("wd_error_cleared", Error, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/proc_feeder.md
Name: proc_feeder

Overview:
- Program sequencer directly upstream of the processor core.
- Holds a small loadable program RAM of 16-bit instruction words and drives the core's DIN and Run.
- Issues one instruction at a time from address 0 to Last_addr, waits for the core's Done, then advances.
- Supplies the immediate word on the cycle after an mvi instruction word.

Parameters:
- DEPTH, 32, number of 16-bit program words (power of two, 4..256).
- AW, $clog2(DEPTH), program address width.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Load_en  in  1  write Load_data to RAM at Load_addr (honoured only in IDLE).
- Load_addr  in  AW  RAM write address.
- Load_data  in  16  instruction or immediate word.
- Start  in  1  begin program run (honoured only in IDLE).
- Last_addr  in  AW  last program address; sampled on the accepted Start.
- Done  in  1  core instruction-complete strobe.
- DIN  out  16  word presented to the core.
- Run  out  1  high while an instruction is in flight.
- Busy  out  1  high in any state other than IDLE.
- Finished  out  1  one-cycle pulse after the last instruction completes.
- Pc  out  AW  address of the current instruction word.

Behaviour:
- Reset: state IDLE; Pc=0; DIN=0; Run=0; Busy=0; Finished=0; latched last address=0. RAM contents are not cleared. Reset mid-run aborts immediately with the same values.
- RAM: one synchronous write port; one synchronous read port with 1-cycle latency and a registered output.
- DIN is driven from the RAM output register, which updates only on FETCH and ISSUE reads and holds in every other state.
- IDLE:
  - Load_en writes the RAM.
  - Start latches Last_addr, sets Pc=0, and goes to FETCH.
  - Load_en and Start in the same cycle: both take effect, and the written word is visible to the run.
- FETCH (Run=0): read address = Pc. Next state: ISSUE.
- ISSUE (Run=1): DIN = mem[Pc] (core latches IR this cycle); read address = Pc+1 mod DEPTH.
  - Opcode DIN[15:13]==001 (mvi): go to IMM.
  - Otherwise: go to WAIT.
  - Done is ignored in ISSUE.
- IMM (Run=1): DIN = mem[Pc+1].
  - Done=1: complete with step=2.
  - Otherwise: go to WAIT with step=2.
- WAIT (Run=1): DIN held.
  - Done=1: complete with the recorded step (1, or 2 for mvi).
- Complete:
  - next = Pc + step, computed in AW+1 bits.
  - If next > latched Last_addr: go to IDLE, Pc=0, pulse Finished, Run=0.
  - Otherwise: Pc = next[AW-1:0] and go to FETCH.
- Boundaries:
  - mvi at Last_addr reads its immediate from Last_addr+1 with wrap to address 0 when Last_addr=DEPTH-1, then finishes.
  - Last_addr=0 runs exactly one instruction.
  - Start, Load_en and Last_addr are ignored while Busy.
  - Done while IDLE or FETCH has no effect.
- Latency: a non-mvi instruction takes at least 3 cycles from FETCH to completion (FETCH, ISSUE, WAIT with Done).

Optional Feature:
- Macro PROC_FEEDER_WDOG_EN.
- Defined:
  - Adds parameter WDOG_CYC (default 15) and output Error (1 bit, reset 0).
  - A cycle counter clears on entering ISSUE.
  - If Done is not seen within WDOG_CYC cycles after ISSUE, the block sets Error (sticky until Reset or the next accepted Start), goes to IDLE with Pc=0 and Run=0, and does not pulse Finished.
- Undefined: no counter and no Error port; WAIT waits indefinitely.

Decomposition:
- Package proc_pkg holds:
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011;
  - field slice constants: opcode [15:13], X [12:10], Y [9:7];
  - state enum feeder_state_t {IDLE, FETCH, ISSUE, IMM, WAIT}.
- One sub-module, prog_ram: DEPTH x 16, synchronous write and registered read.

Test Plan:
- Load 0:mvi R0 (16'h2000), 1:16'h0005, 2:mv R1,R0 (16'h0400); Last_addr=2; Start; model Done on the IMM cycle and 1 cycle after ISSUE otherwise -> DIN sequence 2000, 0005, 0400; Finished pulses once; Pc returns to 0.
- Last_addr=0, word 16'h4000 (add), Done withheld 5 cycles -> Run held high and DIN stable for 5 cycles; Finished one cycle after Done.
- DEPTH=4, Last_addr=3, mvi at address 3 -> immediate taken from address 0; run ends after it with no extra fetch.
- Reset asserted in WAIT -> next cycle Busy=0, Run=0, DIN=0, Pc=0; RAM contents intact on the next run.
- Start while Busy and Load_en while Busy -> no restart and no RAM change; Load_en+Start together in IDLE -> new word issued at address 0.
- With PROC_FEEDER_WDOG_EN and WDOG_CYC=15: Done never asserted -> Error=1 after 15 cycles, IDLE, no Finished; the next Start clears Error.
